// File: rtl/accum12_if.sv
// ---------------------------------------------------------------------------
// accum12_if -- operand / result handshake bundle for accum12.
//
// Signals
//   start      master->slave  begin a transaction (honoured only when idle)
//   a          master->slave  12-bit operand word
//   cin        master->slave  carry-in added together with a
//   in_valid   master->slave  a/cin pair presented this cycle
//   in_ready   slave->master  block accepts an operand this cycle
//   out_ready  master->slave  downstream consumes the result
//   out_valid  slave->master  acc/cout/ovf/count hold a completed result
//   acc        slave->master  running / final sum modulo 4096
//   cout       slave->master  carry-out of the most recent addition
//   ovf        slave->master  sticky OR of all carry-outs this transaction
//   count      slave->master  operands accepted this transaction
// ---------------------------------------------------------------------------
interface accum12_if;
    logic        start;
    logic [11:0] a;
    logic        cin;
    logic        in_valid;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic [11:0] acc;
    logic        cout;
    logic        ovf;
    logic [3:0]  count;

    modport master (
        output start, a, cin, in_valid, out_ready,
        input  in_ready, out_valid, acc, cout, ovf, count
    );

    modport slave (
        input  start, a, cin, in_valid, out_ready,
        output in_ready, out_valid, acc, cout, ovf, count
    );
endinterface

// File: rtl/accum12.sv
// ---------------------------------------------------------------------------
// accum12 -- sums NUM_OPS 12-bit operands (each with its own carry-in) into a
// 12-bit accumulator, tracking the last carry-out and a sticky overflow flag.
//
// Parameters
//   NUM_OPS   operands per transaction, 1..15
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   bus       accum12_if.slave handshake bundle (see accum12_if.sv)
//
// Flow: IDLE --start--> ACCUM --NUM_OPS acceptances--> DONE --out_ready--> IDLE
// in_ready / out_valid are decoded purely from state and the datapath is fully
// registered, so there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module accum12 #(
    parameter int NUM_OPS = 4
) (
    input  logic      clk,
    input  logic      rst,
    accum12_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Count value held just before the final acceptance of a transaction.
    localparam logic [3:0] LAST_COUNT = 4'(NUM_OPS - 1);

    state_t      state, state_next;
    logic [11:0] acc_q;
    logic        cout_q;
    logic        ovf_q;
    logic [3:0]  count_q;
    logic        accept;
    logic [12:0] sum;

    assign accept = (state == ACCUM) && bus.in_valid;

    // 13-bit sum: bit 12 is the carry-out of this addition.
    assign sum = {1'b0, acc_q} + {1'b0, bus.a} + {12'd0, bus.cin};

    // NOTE: every combinationally assigned signal gets a default before the
    // case statement, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start)                         state_next = ACCUM;
            ACCUM:   if (accept && (count_q == LAST_COUNT)) state_next = DONE;
            DONE:    if (bus.out_ready)                     state_next = IDLE;
            default:                                        state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the result registers are reset along with the FSM because their
    // values are architecturally visible right after reset, not just after start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= 12'd0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= 4'd0;
        end else if ((state == IDLE) && bus.start) begin
            acc_q   <= 12'd0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= 4'd0;
        end else if (accept) begin
            acc_q   <= sum[11:0];
            cout_q  <= sum[12];
            ovf_q   <= ovf_q | sum[12];
            count_q <= count_q + 4'd1;
        end
        // Otherwise (stall, DONE, IDLE without start) everything holds, so the
        // last result stays readable after the block returns to IDLE.
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.acc       = acc_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_accum12.sv
// ---------------------------------------------------------------------------
// tb_accum12 -- self-checking bench for accum12 (NUM_OPS=4 and NUM_OPS=1).
// Stimulus pushes hand-computed expectations into queues; negedge monitors pop
// and compare per-acceptance updates and completed results.
// ---------------------------------------------------------------------------
module tb_accum12;

    typedef struct {
        logic [11:0] acc;
        logic        cout;
        logic        ovf;
        logic [3:0]  count;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    accum12_if bus4 ();
    accum12_if bus1 ();

    accum12 #(.NUM_OPS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    accum12 #(.NUM_OPS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;

    res_t step_q[$];
    res_t res_q[$];
    res_t res1_q[$];

    // Hand-computed vectors: row 0 = overflow path, row 1 = no-overflow path.
    logic [11:0] op_a   [2][4] = '{'{12'hFC0, 12'h03F, 12'h001, 12'h0E5},
                                   '{12'h0E5, 12'h02B, 12'h000, 12'h100}};
    logic        op_c   [2][4] = '{'{1'b0, 1'b0, 1'b0, 1'b1},
                                   '{1'b1, 1'b0, 1'b0, 1'b0}};
    logic [11:0] ex_acc [2][4] = '{'{12'hFC0, 12'hFFF, 12'h000, 12'h0E6},
                                   '{12'h0E6, 12'h111, 12'h111, 12'h211}};
    logic        ex_cout[2][4] = '{'{1'b0, 1'b0, 1'b1, 1'b0},
                                   '{1'b0, 1'b0, 1'b0, 1'b0}};
    logic        ex_ovf [2][4] = '{'{1'b0, 1'b0, 1'b1, 1'b1},
                                   '{1'b0, 1'b0, 1'b0, 1'b0}};

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- monitor for the NUM_OPS=4 instance ----------------
    logic pend4 = 1'b0;
    logic done4 = 1'b0;
    res_t held4;

    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            pend4 = 1'b0;
            done4 = 1'b0;
        end else begin
            if (pend4) begin
                if (step_q.size() == 0) begin
                    check("step_unexpected", 1, 0);
                end else begin
                    e = step_q.pop_front();
                    check("step_acc",   int'(bus4.acc),   int'(e.acc));
                    check("step_cout",  int'(bus4.cout),  int'(e.cout));
                    check("step_ovf",   int'(bus4.ovf),   int'(e.ovf));
                    check("step_count", int'(bus4.count), int'(e.count));
                end
            end
            if (bus4.out_valid) begin
                if (!done4) begin
                    done4 = 1'b1;
                    if (res_q.size() == 0) begin
                        check("result_unexpected", 1, 0);
                    end else begin
                        held4 = res_q.pop_front();
                        check("result_acc",   int'(bus4.acc),   int'(held4.acc));
                        check("result_cout",  int'(bus4.cout),  int'(held4.cout));
                        check("result_ovf",   int'(bus4.ovf),   int'(held4.ovf));
                        check("result_count", int'(bus4.count), int'(held4.count));
                    end
                end else begin
                    // While DONE persists the result must not move.
                    check("hold_result",
                          int'({bus4.acc, bus4.cout, bus4.ovf, bus4.count}),
                          int'({held4.acc, held4.cout, held4.ovf, held4.count}));
                    check("hold_in_ready", int'(bus4.in_ready), 0);
                end
            end else begin
                done4 = 1'b0;
            end
            pend4 = bus4.in_valid && bus4.in_ready;
        end
    end

    // ---------------- monitor for the NUM_OPS=1 instance ----------------
    logic done1 = 1'b0;

    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            done1 = 1'b0;
        end else if (bus1.out_valid) begin
            if (!done1) begin
                done1 = 1'b1;
                if (res1_q.size() == 0) begin
                    check("n1_unexpected", 1, 0);
                end else begin
                    e = res1_q.pop_front();
                    check("n1_acc",   int'(bus1.acc),   int'(e.acc));
                    check("n1_cout",  int'(bus1.cout),  int'(e.cout));
                    check("n1_ovf",   int'(bus1.ovf),   int'(e.ovf));
                    check("n1_count", int'(bus1.count), int'(e.count));
                end
            end
        end else begin
            done1 = 1'b0;
        end
    end

    // ---------------- stimulus helpers (enter/leave at posedge+1) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
    endtask

    // Issue operands 0..n-1 of vector row s, with gap idle cycles before each.
    task automatic run_ops(input int s, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step_q.push_back('{ex_acc[s][i], ex_cout[s][i], ex_ovf[s][i], 4'(i + 1)});
            repeat (gap) begin
                check("stall_count", int'(bus4.count), i);
                tick();
            end
            bus4.a        = op_a[s][i];
            bus4.cin      = op_c[s][i];
            bus4.in_valid = 1'b1;
            tick();
            bus4.in_valid = 1'b0;
            bus4.a        = 12'hABC;
            bus4.cin      = 1'b1;
        end
    endtask

    task automatic push_result(input int s);
        res_q.push_back('{ex_acc[s][3], ex_cout[s][3], ex_ovf[s][3], 4'd4});
    endtask

    // Bounded wait for out_valid, then release with out_ready.
    task automatic finish_txn(input int s, input int hold, input logic pulse_start);
        int waited = 0;
        while (!bus4.out_valid && waited < 20) begin
            tick();
            waited++;
        end
        check("done_reached", int'(bus4.out_valid), 1);
        for (int i = 0; i < hold; i++) begin
            bus4.start = pulse_start;
            tick();
            bus4.start = 1'b0;
            check("bp_out_valid", int'(bus4.out_valid), 1);
        end
        bus4.out_ready = 1'b1;
        bus4.start     = pulse_start;   // a start coincident with out_ready is ignored
        tick();
        bus4.out_ready = 1'b0;
        bus4.start     = 1'b0;
        check("idle_out_valid", int'(bus4.out_valid), 0);
        check("idle_acc_kept",  int'(bus4.acc),       int'(ex_acc[s][3]));
        check("idle_count_kept", int'(bus4.count),    4);
        tick();
        check("idle_in_ready",  int'(bus4.in_ready),  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        {bus4.start, bus4.a, bus4.cin, bus4.in_valid, bus4.out_ready} = '0;
        {bus1.start, bus1.a, bus1.cin, bus1.in_valid, bus1.out_ready} = '0;

        // Reset state.
        #3;
        check("rst_acc",       int'(bus4.acc),       0);
        check("rst_flags",     int'({bus4.cout, bus4.ovf}), 0);
        check("rst_count",     int'(bus4.count),     0);
        check("rst_handshake", int'({bus4.in_ready, bus4.out_valid}), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        tick();
        tick();
        check("post_rst_idle", int'(bus4.in_ready), 0);

        // Overflow path with backpressure and ignored start pulses.
        push_result(0);
        do_start();
        check("accum_in_ready", int'(bus4.in_ready), 1);
        run_ops(0, 4, 0);
        check("done_in_ready", int'(bus4.in_ready), 0);
        finish_txn(0, 5, 1'b1);

        // No-overflow path.
        push_result(1);
        do_start();
        run_ops(1, 4, 0);
        finish_txn(1, 0, 1'b0);

        // Same operands with three stall cycles, in_valid held high in DONE.
        push_result(1);
        do_start();
        run_ops(1, 4, 3);
        bus4.in_valid = 1'b1;
        bus4.a        = 12'h7FF;
        repeat (3) tick();
        bus4.in_valid = 1'b0;
        check("done_no_accept", int'(bus4.count), 4);
        finish_txn(1, 0, 1'b0);

        // Reset mid-transaction after two accepted operands.
        do_start();
        run_ops(1, 2, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_acc",   int'(bus4.acc),   0);
        check("midrst_count", int'(bus4.count), 0);
        check("midrst_ready", int'(bus4.in_ready), 0);
        check("midrst_steps_done", step_q.size(), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        tick();
        tick();
        check("midrst_idle", int'(bus4.in_ready), 0);
        push_result(1);
        do_start();
        run_ops(1, 4, 0);
        finish_txn(1, 0, 1'b0);

        // NUM_OPS=1: single acceptance wraps and finishes.
        res1_q.push_back('{12'h000, 1'b1, 1'b1, 4'd1});
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check("n1_in_ready", int'(bus1.in_ready), 1);
        bus1.a        = 12'hFFF;
        bus1.cin      = 1'b1;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        check("n1_done", int'({bus1.out_valid, bus1.in_ready}), 2);
        tick();
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        check("n1_idle", int'(bus1.out_valid), 0);

        tick();
        check("queues_drained", step_q.size() + res_q.size() + res1_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
